// File: rtl/onehot_encoder_8to3_seq.sv
// onehot_encoder_8to3_seq
// Sequential 8-to-3 encoder. Captures an 8-bit request vector through a
// valid/ready handshake and replays the binary index of every set bit, lowest
// index first, one index per output handshake.
// Optional feature macro: ENC_CNT_EN adds a registered remaining-index counter
// output (cnt).
module onehot_encoder_8to3_seq #(
  parameter int N_IN  = 8,
  parameter int W_OUT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_IN-1:0]   A,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [W_OUT-1:0]  Y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
`ifdef ENC_CNT_EN
  output logic [3:0]        cnt,
`endif
  output logic              zero_err
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Index of the lowest set bit; 0 for an all-zero vector (never used then).
  function automatic logic [2:0] low_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Number of set bits, 0..8.
  function automatic logic [3:0] popcnt(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

  state_t      state_r, state_s;
  logic [7:0]  pend_r, pend_s;
  logic [7:0]  rem_s;
  logic [2:0]  y_r, y_s;
  logic        ov_r, ov_s;
  logic        ol_r, ol_s;
  logic        ze_r, ze_s;

  // Ready is decoded from registered state only, and forced low during reset.
  assign in_ready  = (state_r == IDLE) && !rst;
  assign Y         = y_r;
  assign out_valid = ov_r;
  assign out_last  = ol_r;
  assign zero_err  = ze_r;

  // Pending bits left after retiring the index currently presented on Y.
  always_comb begin
    rem_s = pend_r & ~(8'b0000_0001 << y_r);
  end

  // Next-state and next-output decode for the capture/emit sequencer.
  always_comb begin
    state_s = state_r;
    pend_s  = pend_r;
    y_s     = y_r;
    ov_s    = ov_r;
    ol_s    = ol_r;
    ze_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          pend_s = A;
          if (A != 8'h00) begin
            state_s = EMIT;
            y_s     = low_idx(A);
            ov_s    = 1'b1;
            ol_s    = (popcnt(A) == 4'd1);
          end else begin
            ze_s    = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      EMIT: begin
        if (out_ready) begin
          pend_s = rem_s;
          if (ol_r) begin
            state_s = IDLE;
            ov_s    = 1'b0;
            ol_s    = 1'b0;
            y_s     = 3'd0;
          end else begin
            y_s     = low_idx(rem_s);
            ol_s    = (popcnt(rem_s) == 4'd1);
          end
        end else begin
          state_s = EMIT;
        end
      end
      default: begin
        state_s = IDLE;
        pend_s  = 8'h00;
        y_s     = 3'd0;
        ov_s    = 1'b0;
        ol_s    = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      pend_r  <= 8'h00;
      y_r     <= 3'd0;
      ov_r    <= 1'b0;
      ol_r    <= 1'b0;
      ze_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      pend_r  <= pend_s;
      y_r     <= y_s;
      ov_r    <= ov_s;
      ol_r    <= ol_s;
      ze_r    <= ze_s;
    end
  end

`ifdef ENC_CNT_EN
  logic [3:0] cnt_r, cnt_s;

  assign cnt = cnt_r;

  // Remaining-index count: loaded with popcount on capture, one less per
  // output handshake, so it reaches zero with the last handshake.
  always_comb begin
    cnt_s = cnt_r;
    if (state_r == IDLE) begin
      if (in_valid) begin
        cnt_s = popcnt(A);
      end else begin
        cnt_s = cnt_r;
      end
    end else begin
      if (out_ready && (cnt_r != 4'd0)) begin
        cnt_s = cnt_r - 4'd1;
      end else begin
        cnt_s = cnt_r;
      end
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= 4'd0;
    end else begin
      cnt_r <= cnt_s;
    end
  end
`endif

endmodule

// File: tb/tb_onehot_encoder_8to3_seq.sv
// Self-checking bench for onehot_encoder_8to3_seq. Expected {last, index}
// pairs are queued when a vector is driven and popped as outputs appear.
// Build with ENC_CNT_EN defined to also check the cnt port.
module tb_onehot_encoder_8to3_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] A;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] Y;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       zero_err;
`ifdef ENC_CNT_EN
  logic [3:0] cnt;
`endif

  int total = 0;
  int bad   = 0;
  logic [3:0] q[$];   // {last, index}

  onehot_encoder_8to3_seq dut (
    .clk(clk), .rst(rst), .A(A), .in_valid(in_valid), .in_ready(in_ready),
    .Y(Y), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
`ifdef ENC_CNT_EN
    .cnt(cnt),
`endif
    .zero_err(zero_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: expected indices of every set bit, lowest first, last flagged.
  task automatic push_expected(input logic [7:0] v);
    int first_new;
    first_new = q.size();
    for (int i = 0; i < 8; i++) begin
      if (v[i]) q.push_back({1'b0, 3'(i)});
    end
    if (q.size() > first_new) q[q.size()-1][3] = 1'b1;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // Drive one vector for one accepted handshake; outputs of the capture edge
  // are visible on return.
  task automatic send(input logic [7:0] v);
    A = v;
    in_valid = 1'b1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL send_ready got=%0b expected=1", in_ready);
    end
    push_expected(v);
    step();
    in_valid = 1'b0;
  endtask

  // Pop and compare every queued index with out_ready held high.
  task automatic drain();
    logic [3:0] e;
    out_ready = 1'b1;
    while (q.size() > 0) begin
      e = q[0];
      total++;
      if (out_valid !== 1'b1 || Y !== e[2:0] || out_last !== e[3] || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL drain_out got v=%0b Y=%0d last=%0b rdy=%0b expected v=1 Y=%0d last=%0b rdy=0",
                 out_valid, Y, out_last, in_ready, e[2:0], e[3]);
      end
`ifdef ENC_CNT_EN
      total++;
      if (cnt !== 4'(q.size())) begin
        bad++;
        $display("FAIL drain_cnt got=%0d expected=%0d", cnt, q.size());
      end
`endif
      void'(q.pop_front());
      step();
    end
    total++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || Y !== 3'd0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL drain_end got v=%0b last=%0b Y=%0d rdy=%0b expected v=0 last=0 Y=0 rdy=1",
               out_valid, out_last, Y, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; A = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
    step();
    step();
    chk("reset_ready", in_ready, 0);
    chk("reset_valid", out_valid, 0);
    chk("reset_y", Y, 0);
    chk("reset_last", out_last, 0);
    chk("reset_zero_err", zero_err, 0);
`ifdef ENC_CNT_EN
    chk("reset_cnt", cnt, 0);
`endif
    rst = 1'b0;
    #1;
    chk("reset_release_ready", in_ready, 1);
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    send(8'b0000_0100);
    drain();
  endtask

  task automatic test_multi();
    out_ready = 1'b1;
    send(8'b1010_0010);
    drain();
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    send(8'b0001_1000);
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_y", Y, q[0][2:0]);
      chk("stall_last", out_last, 0);
`ifdef ENC_CNT_EN
      chk("stall_cnt", cnt, 2);
`endif
      step();
    end
    drain();
  endtask

  task automatic test_zero();
    out_ready = 1'b1;
    send(8'h00);
    chk("zero_err_pulse", zero_err, 1);
    chk("zero_valid", out_valid, 0);
    chk("zero_ready", in_ready, 1);
`ifdef ENC_CNT_EN
    chk("zero_cnt", cnt, 0);
`endif
    step();
    chk("zero_err_clear", zero_err, 0);
    chk("zero_valid2", out_valid, 0);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    send(8'hFF);
    A = 8'h01;
    in_valid = 1'b1;          // ignored while emitting
    drain();
    push_expected(8'h01);     // captured only now that in_ready is back
    step();
    in_valid = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    send(8'hF0);
    chk("mid_y4", Y, 4);
    step();
    chk("mid_y5", Y, 5);
    step();                   // Y=5 handshake
    chk("mid_y6", Y, 6);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", in_ready, 0);
    step();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_y", Y, 0);
    chk("mid_rst_last", out_last, 0);
`ifdef ENC_CNT_EN
    chk("mid_rst_cnt", cnt, 0);
`endif
    rst = 1'b0;
    q.delete();
    #1;
    chk("mid_release_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid_no_resume", out_valid, 0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_stall();
    test_zero();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
